lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory-stage load/store unit placed directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, issues one word-aligned data-memory request with byte-lane write enables, and waits for the load response. It then aligns and sign- or zero-extends the returned data and presents a one-cycle writeback pulse to the register-file write port. Handles one transaction at a time; back-pressures execute through `in_ready`.

## Interface
- `ADDR_W`, default 32: effective address width (bits [1:0] select byte lane).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute stage presents a memory op this cycle.
- `in_ready` out 1: unit can accept an op (high only in IDLE, low while `rst`).
- `in_addr` in ADDR_W: effective address (ALU `Out`).
- `in_wdata` in 32: store data (rs2).
- `in_is_store` in 1: 1 = store, 0 = load.
- `in_funct3` in 3: load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
- `in_rd` in 5: load destination register.
- `dmem_req_valid` out 1: request valid.
- `dmem_req_ready` in 1: memory accepts request this cycle.
- `dmem_addr` out ADDR_W: `{addr[ADDR_W-1:2],2'b00}`.
- `dmem_we` out 4: byte write mask, 0000 for loads.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_resp_valid` in 1: load data valid.
- `dmem_resp_data` in 32: returned word.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_rd` out 5, `wb_data` out 32: writeback register and value.
- `fault` out 1: one-cycle pulse, misaligned or illegal funct3.
- `fault_addr` out ADDR_W: offending address, valid with `fault`.

## Operation
- States: IDLE, REQ, WAIT. Reset -> IDLE; all outputs 0 on reset and during `rst` (including `in_ready`).
- IDLE: `in_ready`=1. On `in_valid`: latch addr, wdata, funct3, is_store, rd.
  - Fault check: halfword with addr[0]=1; word with addr[1:0]≠00; load funct3 ∈ {011,110,111}; store funct3 ≥ 011. A fault registers `fault`=1 and `fault_addr` for the next cycle. The unit stays in IDLE, issues no request and produces no writeback.
  - Otherwise go to REQ.
- REQ: `dmem_req_valid`=1. `dmem_addr`, `dmem_we` and `dmem_wdata` come from latched values and stay stable until accepted.
  - On `dmem_req_ready`: a store goes to IDLE (complete on acceptance, no wb); a load goes to WAIT.
- WAIT: on `dmem_resp_valid`, register `wb_valid`=1, `wb_rd`, and the extracted data. Go to IDLE in the same edge.
- Store lanes:
  - SB: wdata = {4{b[7:0]}}, we = 0001 << addr[1:0].
  - SH: wdata = {2{b[15:0]}}, we = addr[1] ? 1100 : 0011.
  - SW: wdata as-is, we = 1111.
- Load extraction: shifted = resp_data >> (8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is unmodified.
- rd=0 loads still access memory and pulse `wb_valid` with `wb_rd`=0. The register file ignores x0.
- `dmem_resp_valid` outside WAIT is ignored.
- `rst` in any state aborts the transaction. A response arriving after reset is ignored.
- `wb_valid` and `fault` are never asserted together.

## Timing
- Op accepted at edge T (in IDLE): `dmem_req_valid` is high in cycle T+1.
- Store with ready in T+1: `in_ready` is high again in cycle T+2.
- Load with ready in T+1 and response in T+2: `wb_valid` is high in cycle T+3. `in_ready` is high in T+3, so a new op can be accepted at the T+3 edge.
- Minimum occupancy: 2 cycles per store, 3 per load. Each cycle of `dmem_req_ready`=0 or missing response adds one.
- `fault` is high in cycle T+1; `in_ready` stays 1 throughout.
- `wb_*` and `fault*` are registered outputs. `dmem_*` outputs are driven from registered state only, with no combinational path from `in_*`.

## Test plan
- LB addr 0x1003, resp 0x80FF_0000 -> `wb_data`=0xFFFF_FF80, `dmem_addr`=0x1000, `dmem_we`=0000, `wb_valid` 3 cycles after accept.
- LHU addr 0x2002, resp 0xBEEF_1234 -> `wb_data`=0x0000_BEEF. LH on the same data -> 0xFFFF_BEEF.
- SB addr 0x11, wdata 0x0000_00AB -> `dmem_addr`=0x10, `we`=0010, `wdata`=0xABAB_ABAB, no `wb_valid`, `in_ready` back after 2 cycles.
- SW with `dmem_req_ready` low for 3 cycles -> addr/we/wdata held constant, store completes on the first ready cycle.
- LW addr 0x4002 -> `fault`=1 with `fault_addr`=0x4002, no `dmem_req_valid`. Load funct3=011 -> `fault`. Next valid op is accepted immediately.
- `rst` asserted while in WAIT, then `dmem_resp_valid` pulses -> no `wb_valid`, state IDLE, all outputs 0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one outstanding data-memory access at a time,
// byte-lane store formatting, load alignment/extension and a registered writeback pulse.
module lsu_mem_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   input  logic              in_is_store,
   input  logic [2:0]        in_funct3,
   input  logic [4:0]        in_rd,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_we,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_resp_valid,
   input  logic [31:0]       dmem_resp_data,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic              is_store_q;
   logic [4:0]        rd_q;
   logic [3:0]        we_q;
   logic [31:0]       wdata_q;
   logic              wb_valid_q, fault_q;
   logic [4:0]        wb_rd_q;
   logic [31:0]       wb_data_q;
   logic [ADDR_W-1:0] fault_addr_q;

   logic        accept, bad;
   logic [3:0]  we_n;
   logic [31:0] wdata_n, shifted, ext;

   assign accept = in_valid && (state == IDLE);

   // funct3[1:0] encodes access size for both loads and stores
   always_comb begin
      bad = 1'b0;
      if (in_is_store && (in_funct3 >= 3'b011))                          bad = 1'b1;
      if (!in_is_store && ((in_funct3[1:0] == 2'b11) || (in_funct3 == 3'b110))) bad = 1'b1;
      if ((in_funct3[1:0] == 2'b01) && in_addr[0])                       bad = 1'b1;
      if ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00))         bad = 1'b1;
   end

   always_comb begin
      we_n    = 4'b0000;
      wdata_n = 32'h0;
      if (in_is_store) begin
         case (in_funct3[1:0])
            2'b00: begin
               we_n    = 4'b0001 << in_addr[1:0];
               wdata_n = {4{in_wdata[7:0]}};
            end
            2'b01: begin
               we_n    = in_addr[1] ? 4'b1100 : 4'b0011;
               wdata_n = {2{in_wdata[15:0]}};
            end
            default: begin
               we_n    = 4'b1111;
               wdata_n = in_wdata;
            end
         endcase
      end
   end

   assign shifted = dmem_resp_data >> {addr_q[1:0], 3'b000};

   always_comb begin
      ext = shifted;
      case (funct3_q)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext = {24'h0, shifted[7:0]};
         3'b101:  ext = {16'h0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && !bad) state_next = REQ;
         REQ:     if (dmem_req_ready) state_next = is_store_q ? IDLE : WAIT;
         WAIT:    if (dmem_resp_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         funct3_q     <= '0;
         is_store_q   <= 1'b0;
         rd_q         <= '0;
         we_q         <= '0;
         wdata_q      <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         if (accept) begin
            if (bad) begin
               fault_q      <= 1'b1;
               fault_addr_q <= in_addr;
            end else begin
               addr_q     <= in_addr;
               funct3_q   <= in_funct3;
               is_store_q <= in_is_store;
               rd_q       <= in_rd;
               we_q       <= we_n;
               wdata_q    <= wdata_n;
            end
         end
         if ((state == WAIT) && dmem_resp_valid) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= ext;
         end
      end
   end

   // Outputs are forced low while reset is held, even before the reset edge
   assign in_ready       = !rst && (state == IDLE);
   assign dmem_req_valid = !rst && (state == REQ);
   assign dmem_addr      = rst ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
   assign dmem_we        = rst ? '0 : we_q;
   assign dmem_wdata     = rst ? '0 : wdata_q;
   assign wb_valid       = !rst && wb_valid_q;
   assign wb_rd          = rst ? '0 : wb_rd_q;
   assign wb_data        = rst ? '0 : wb_data_q;
   assign fault          = !rst && fault_q;
   assign fault_addr     = rst ? '0 : fault_addr_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_is_store;
   logic [31:0] in_addr, in_wdata;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic        dmem_req_valid, dmem_req_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_resp_data;
   logic [3:0]  dmem_we;
   logic        dmem_resp_valid;
   logic        wb_valid, fault;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, fault_addr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_is_store(in_is_store), .in_funct3(in_funct3), .in_rd(in_rd),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .fault(fault), .fault_addr(fault_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents an op for one cycle; returns at the falling edge of the cycle after acceptance.
   task automatic present(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd);
      in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Runs a load through REQ (ready at once) and WAIT (response next cycle); checks writeback.
   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] resp, input logic [4:0] rd, input logic [31:0] exp);
      present(1'b0, f3, a, 32'h0, rd);
      chk({tag, "_req_valid"}, {31'h0, dmem_req_valid}, 32'h1);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b1; dmem_resp_data = resp;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      chk({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'h1);
      chk({tag, "_wb_data"}, wb_data, exp);
      chk({tag, "_wb_rd"}, {27'h0, wb_rd}, {27'h0, rd});
      @(negedge clk);
      chk({tag, "_wb_pulse"}, {31'h0, wb_valid}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b0; in_addr = 32'h0;
      in_wdata = 32'h0; in_rd = 5'd0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
      dmem_resp_data = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'h0, in_ready}, 32'h1);

      // LB 0x1003: detailed cycle-by-cycle check
      present(1'b0, 3'b000, 32'h1003, 32'h0, 5'd5);
      chk("lb_req_valid", {31'h0, dmem_req_valid}, 32'h1);
      chk("lb_addr", dmem_addr, 32'h1000);
      chk("lb_we", {28'h0, dmem_we}, 32'h0);
      chk("lb_in_ready_busy", {31'h0, in_ready}, 32'h0);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("lb_wait_no_req", {31'h0, dmem_req_valid}, 32'h0);
      chk("lb_wait_no_wb", {31'h0, wb_valid}, 32'h0);
      dmem_resp_valid = 1'b1; dmem_resp_data = 32'h80FF_0000;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      chk("lb_wb_valid_t3", {31'h0, wb_valid}, 32'h1);
      chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
      chk("lb_wb_rd", {27'h0, wb_rd}, 32'd5);
      chk("lb_in_ready_t3", {31'h0, in_ready}, 32'h1);
      @(negedge clk);

      load("lhu", 3'b101, 32'h2002, 32'hBEEF_1234, 5'd7, 32'h0000_BEEF);
      load("lh", 3'b001, 32'h2002, 32'hBEEF_1234, 5'd8, 32'hFFFF_BEEF);
      load("lbu", 3'b100, 32'h3001, 32'h0000_9A00, 5'd9, 32'h0000_009A);
      load("lw", 3'b010, 32'h3004, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D);

      // SB 0x11
      present(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 5'd0);
      chk("sb_addr", dmem_addr, 32'h10);
      chk("sb_we", {28'h0, dmem_we}, 32'h2);
      chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("sb_in_ready_t2", {31'h0, in_ready}, 32'h1);
      chk("sb_no_wb", {31'h0, wb_valid}, 32'h0);
      chk("sb_no_req", {31'h0, dmem_req_valid}, 32'h0);

      // SH upper half
      present(1'b1, 3'b001, 32'h22, 32'h1111_5678, 5'd0);
      chk("sh_we", {28'h0, dmem_we}, 32'hC);
      chk("sh_wdata", dmem_wdata, 32'h5678_5678);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;

      // SW with three stalled cycles
      present(1'b1, 3'b010, 32'h40, 32'h1234_5678, 5'd0);
      for (int i = 0; i < 3; i++) begin
         chk("sw_stall_valid", {31'h0, dmem_req_valid}, 32'h1);
         chk("sw_stall_addr", dmem_addr, 32'h40);
         chk("sw_stall_we", {28'h0, dmem_we}, 32'hF);
         chk("sw_stall_wdata", dmem_wdata, 32'h1234_5678);
         @(negedge clk);
      end
      chk("sw_still_valid", {31'h0, dmem_req_valid}, 32'h1);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("sw_done_in_ready", {31'h0, in_ready}, 32'h1);
      chk("sw_done_no_req", {31'h0, dmem_req_valid}, 32'h0);

      // Misaligned LW, then illegal load funct3 accepted back-to-back
      present(1'b0, 3'b010, 32'h4002, 32'h0, 5'd3);
      chk("lw_mis_fault", {31'h0, fault}, 32'h1);
      chk("lw_mis_fault_addr", fault_addr, 32'h4002);
      chk("lw_mis_no_req", {31'h0, dmem_req_valid}, 32'h0);
      chk("lw_mis_in_ready", {31'h0, in_ready}, 32'h1);
      chk("lw_mis_no_wb", {31'h0, wb_valid}, 32'h0);
      present(1'b0, 3'b011, 32'h4000, 32'h0, 5'd3);
      chk("f3_011_fault", {31'h0, fault}, 32'h1);
      chk("f3_011_fault_addr", fault_addr, 32'h4000);
      chk("f3_011_no_req", {31'h0, dmem_req_valid}, 32'h0);
      present(1'b0, 3'b010, 32'h4004, 32'h0, 5'd4);
      chk("after_fault_accept", {31'h0, dmem_req_valid}, 32'h1);
      chk("after_fault_clear", {31'h0, fault}, 32'h0);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;

      // Reset while in WAIT, then a late response
      chk("wait_state", {31'h0, in_ready}, 32'h0);
      rst = 1'b1;
      #1;
      chk("rst_wait_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_wait_req", {31'h0, dmem_req_valid}, 32'h0);
      chk("rst_wait_addr", dmem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dmem_resp_valid = 1'b1; dmem_resp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      chk("rst_late_resp_no_wb", {31'h0, wb_valid}, 32'h0);
      chk("rst_idle_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_idle_no_req", {31'h0, dmem_req_valid}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_fault_addr", fault_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
